// File: rtl/uart_mem_dump_pkg.sv
// Shared constants and FSM encoding for the memory-to-serial dumper.
package uart_mem_dump_pkg;

  // CLK cycles per serial bit at 100 MHz / 115200 baud.
  localparam int SERIAL_WCNT_DEFAULT = 868;

  // One 8N1 frame: start + 8 data + stop.
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_mem_dump_if.sv
// Command, memory read port and serial/status lines of the dumper.
// slave = the dumper itself, master = the host/memory side driving it.
interface uart_mem_dump_if #(
  parameter int ADDR_W = 32
);
  logic              START;
  logic [ADDR_W-1:0] BASE;
  logic [31:0]       LEN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RE;
  logic [31:0]       MEM_RDATA;
  logic              TXD;
  logic              BUSY;
  logic              DONE;

  modport slave (
    input  START, BASE, LEN, MEM_RDATA,
    output MEM_ADDR, MEM_RE, TXD, BUSY, DONE
  );

  modport master (
    output START, BASE, LEN, MEM_RDATA,
    input  MEM_ADDR, MEM_RE, TXD, BUSY, DONE
  );
endinterface

// File: rtl/uart_mem_dump_tx.sv
// 8N1 byte transmitter: LOAD while READY starts a frame on the next cycle;
// READY comes back the cycle after the stop bit's last cycle.
module uart_tx_byte
  import uart_mem_dump_pkg::*;
#(
  parameter int SERIAL_WCNT = SERIAL_WCNT_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       LOAD,
  output logic       READY,
  output logic       TXD
);
  localparam int CNT_W = (SERIAL_WCNT > 2) ? $clog2(SERIAL_WCNT) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERIAL_WCNT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [BIT_W-1:0]      bit_reg;
  logic                  busy_reg;

  // Frame engine: load, hold each bit SERIAL_WCNT cycles, shift out LSB first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '1;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      busy_reg  <= 1'b0;
    end else if (!busy_reg) begin
      if (LOAD) begin
        shift_reg <= {1'b1, DIN, 1'b0};
        cnt_reg   <= '0;
        bit_reg   <= '0;
        busy_reg  <= 1'b1;
      end
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
      if (bit_reg == BIT_LAST) begin
        busy_reg <= 1'b0;
      end else begin
        shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
        bit_reg   <= bit_reg + 1'b1;
      end
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // The line is forced high whenever no frame is active, so reset idles it at once.
  assign READY = !busy_reg;
  assign TXD   = busy_reg ? shift_reg[0] : 1'b1;

endmodule

// File: rtl/uart_mem_dump.sv
// Memory-to-serial dumper: reads a word range and sends each word LSB byte first.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int SERIAL_WCNT = SERIAL_WCNT_DEFAULT,
  parameter int ADDR_W      = 32
) (
  input logic            CLK,
  input logic            RST,
  uart_mem_dump_if.slave bus
);
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       nwords_reg, nwords_next;
  logic [31:0]       word_reg, word_next;
  logic [1:0]        idx_reg, idx_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              tx_ready, tx_load, tx_txd, mem_re;
  logic              last_byte;

  assign last_byte = (idx_reg == 2'd3);

  uart_tx_byte #(.SERIAL_WCNT(SERIAL_WCNT)) u_tx (
    .CLK   (CLK),
    .RST   (RST),
    .DIN   (word_reg[7:0]),
    .LOAD  (tx_load),
    .READY (tx_ready),
    .TXD   (tx_txd)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; the next word is fetched while the 4th byte is on the line.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (bus.START) state_next = ((bus.LEN >> 2) == 32'd0) ? ST_FIN : ST_READ;
      ST_READ:  state_next = ST_LATCH;
      ST_LATCH: state_next = ST_SEND;
      ST_SEND:  if (tx_ready && last_byte) state_next = (nwords_reg == 32'd1) ? ST_FIN : ST_READ;
      ST_FIN:   if (tx_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output logic: read strobe only in READ, byte handoff when the transmitter is free.
  always_comb begin
    mem_re  = (state_reg == ST_READ);
    tx_load = (state_reg == ST_SEND) && tx_ready;
  end

  // Datapath next values: address/word counters, byte shifter and status flags.
  always_comb begin
    addr_next   = addr_reg;
    nwords_next = nwords_reg;
    word_next   = word_reg;
    idx_next    = idx_reg;
    busy_next   = busy_reg;
    done_next   = done_reg;
    case (state_reg)
      ST_IDLE: if (bus.START) begin
        addr_next   = bus.BASE & ~ADDR_W'(3);
        nwords_next = bus.LEN >> 2;
        busy_next   = 1'b1;
        done_next   = 1'b0;
      end
      ST_LATCH: begin
        word_next = bus.MEM_RDATA;
        idx_next  = 2'd0;
      end
      ST_SEND: if (tx_ready) begin
        word_next = word_reg >> 8;
        idx_next  = idx_reg + 2'd1;
        if (last_byte) begin
          addr_next   = addr_reg + ADDR_W'(4);
          nwords_next = nwords_reg - 32'd1;
        end
      end
      ST_FIN: if (tx_ready) begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
      default: ;
    endcase
    // The visible read address only moves when a read is about to be issued.
    mem_addr_next = (state_next == ST_READ) ? addr_next : mem_addr_reg;
  end

  // Datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_reg     <= '0;
      mem_addr_reg <= '0;
      nwords_reg   <= '0;
      word_reg     <= '0;
      idx_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      addr_reg     <= addr_next;
      mem_addr_reg <= mem_addr_next;
      nwords_reg   <= nwords_next;
      word_reg     <= word_next;
      idx_reg      <= idx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign bus.MEM_RE   = mem_re;
  assign bus.MEM_ADDR = mem_addr_reg;
  assign bus.TXD      = tx_txd;
  assign bus.BUSY     = busy_reg;
  assign bus.DONE     = done_reg;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump with SERIAL_WCNT=4 and a byte-pattern memory.
module tb_uart_mem_dump;
  localparam int W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] rd_q[$];
  logic        prev_re   = 1'b0;
  logic [31:0] prev_addr = '0;

  uart_mem_dump_if #(.ADDR_W(32)) bus ();

  uart_mem_dump #(.SERIAL_WCNT(W), .ADDR_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] l;
    l = a[7:0];
    return {l + 8'd3, l + 8'd2, l + 8'd1, l};
  endfunction

  // Memory model: data appears only for the cycle after a MEM_RE cycle.
  always @(negedge CLK) begin
    bus.MEM_RDATA = prev_re ? mem_word(prev_addr) : 32'hDEADBEEF;
    prev_re   = (bus.MEM_RE === 1'b1);
    prev_addr = bus.MEM_ADDR;
    if (prev_re) rd_q.push_back(bus.MEM_ADDR);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_dump(input logic [31:0] base, input logic [31:0] len);
    bus.BASE  = base;
    bus.LEN   = len;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    check("busy_after_start", 32'(bus.BUSY), 32'd1);
    check("done_cleared", 32'(bus.DONE), 32'd0);
  endtask

  task automatic rx_byte(output logic [7:0] b, output int gap, input int pulse_at);
    logic [39:0] s;
    logic        ok;
    gap = 0;
    while (bus.TXD !== 1'b0 && gap < 1000) begin
      @(negedge CLK);
      gap++;
    end
    for (int i = 0; i < 40; i++) begin
      s[i] = bus.TXD;
      if (i == pulse_at) bus.START = 1'b1;
      else if (i == pulse_at + 1) bus.START = 1'b0;
      @(negedge CLK);
    end
    ok = (s[3:0] == 4'h0) && (s[39:36] == 4'hF);
    for (int k = 0; k < 10; k++)
      if (s[4*k +: 4] != 4'h0 && s[4*k +: 4] != 4'hF) ok = 1'b0;
    for (int j = 0; j < 8; j++) b[j] = s[4 + 4*j];
    check("frame_shape", 32'(ok), 32'd1);
  endtask

  task automatic dump_and_check(input logic [31:0] base, input logic [31:0] len,
                                input int pulse_byte);
    logic [31:0] ba;
    logic [7:0]  b, exp_b;
    int          nw, gap, n;
    ba = base & ~32'h3;
    nw = int'(len >> 2);
    rd_q.delete();
    start_dump(base, len);
    if (pulse_byte >= 0) begin
      bus.BASE = 32'h500;
      bus.LEN  = 32'h40;
    end
    for (int k = 0; k < nw * 4; k++) begin
      rx_byte(b, gap, (k == pulse_byte) ? 10 : -1);
      exp_b = ba[7:0] + 8'(k);
      $display("dump base=%08h byte %0d: rx=%02h exp=%02h gap=%0d", base, k, b, exp_b, gap);
      check($sformatf("byte%0d", k), 32'(b), 32'(exp_b));
      if (k % 4 == 0) check("gap_word", 32'(gap <= 3), 32'd1);
      else            check("gap_byte", 32'(gap), 32'd1);
    end
    n = 0;
    while (bus.BUSY !== 1'b0 && n < 4) begin
      @(negedge CLK);
      n++;
    end
    check("busy_clear", 32'(bus.BUSY), 32'd0);
    check("done_set", 32'(bus.DONE), 32'd1);
    repeat (6) @(negedge CLK);
    check("still_idle", 32'(bus.BUSY), 32'd0);
    check("read_count", 32'(rd_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < rd_q.size(); i++)
      check($sformatf("read_addr%0d", i), rd_q[i], ba + 32'(4 * i));
  endtask

  initial begin
    int          n;
    logic        idle_ok;
    logic [7:0]  b;
    int          gap;
    bus.START = 1'b0;
    bus.BASE  = '0;
    bus.LEN   = '0;

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_txd", 32'(bus.TXD), 32'd1);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_re", 32'(bus.MEM_RE), 32'd0);
    check("rst_addr", bus.MEM_ADDR, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Two-word dump from 0x100.
    dump_and_check(32'h100, 32'd8, -1);

    // Zero-length dump.
    rd_q.delete();
    start_dump(32'h40, 32'd0);
    n = 1;
    idle_ok = 1'b1;
    while (bus.BUSY !== 1'b0 && n < 6) begin
      @(negedge CLK);
      n++;
      if (bus.TXD !== 1'b1) idle_ok = 1'b0;
    end
    $display("len0: busy cycles=%0d", n - 1);
    check("len0_busy_cycles", 32'(n - 1 <= 3), 32'd1);
    check("len0_done", 32'(bus.DONE), 32'd1);
    check("len0_txd_idle", 32'(idle_ok), 32'd1);
    check("len0_no_read", 32'(rd_q.size()), 32'd0);

    // Unaligned base and partial length collapse to one word.
    dump_and_check(32'h203, 32'd7, -1);

    // START during the 2nd byte is ignored.
    dump_and_check(32'h10, 32'd8, 1);

    // Asynchronous reset during data bit D3 of the first byte.
    rd_q.delete();
    start_dump(32'h300, 32'd4);
    n = 0;
    while (bus.TXD !== 1'b0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    repeat (17) @(negedge CLK);
    check("pre_reset_txd", 32'(bus.TXD), 32'd0);
    RST = 1'b1;
    #1;
    $display("async reset: txd=%b busy=%b re=%b", bus.TXD, bus.BUSY, bus.MEM_RE);
    check("arst_txd", 32'(bus.TXD), 32'd1);
    check("arst_busy", 32'(bus.BUSY), 32'd0);
    check("arst_re", 32'(bus.MEM_RE), 32'd0);
    check("arst_done", 32'(bus.DONE), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    dump_and_check(32'h380, 32'd8, -1);

    // Address wrap at the top of the space.
    dump_and_check(32'hFFFFFFFC, 32'd8, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
